// File: rtl/sram_arbiter.sv
// Two-port arbiter sharing one single-port SRAM with registered read data.
// Define SRAM_ARB_ROUND_ROBIN_EN for round-robin ties; otherwise port 0 has fixed priority.
module sram_arbiter #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_i,
  input  logic              req1_i,
  input  logic              we0_i,
  input  logic              we1_i,
  input  logic [ADDR_W-1:0] addr0_i,
  input  logic [ADDR_W-1:0] addr1_i,
  input  logic [DATA_W-1:0] wdata0_i,
  input  logic [DATA_W-1:0] wdata1_i,
  output logic              ack0_o,
  output logic              ack1_o,
  output logic [DATA_W-1:0] rdata0_o,
  output logic [DATA_W-1:0] rdata1_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic              mem_write_en_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [DATA_W-1:0] mem_rdata_i,
  output logic [1:0]        grant_o
);

`ifdef SRAM_ARB_ROUND_ROBIN_EN
  localparam bit ROUND_ROBIN = 1'b1;
`else
  localparam bit ROUND_ROBIN = 1'b0;
`endif

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_RESP   = 2'd2
  } state_t;

  state_t state;
  logic   last_grant;  // 1 = port 1 owned the previous transaction
  logic   pick1_c;

  // Winner selection; the last-grant pointer only matters on a tie in round-robin builds.
  always_comb begin
    pick1_c = req1_i;
    if (req0_i && req1_i) begin
      pick1_c = ROUND_ROBIN ? ~last_grant : 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state          <= S_IDLE;
      grant_o        <= 2'b00;
      mem_addr_o     <= '0;
      mem_wdata_o    <= '0;
      mem_write_en_o <= 1'b0;
      ack0_o         <= 1'b0;
      ack1_o         <= 1'b0;
      last_grant     <= 1'b1;
    end else begin
      case (state)
        S_IDLE: begin
          ack0_o <= 1'b0;
          ack1_o <= 1'b0;
          if (req0_i || req1_i) begin
            grant_o        <= pick1_c ? 2'b10 : 2'b01;
            mem_addr_o     <= pick1_c ? addr1_i  : addr0_i;
            mem_wdata_o    <= pick1_c ? wdata1_i : wdata0_i;
            mem_write_en_o <= pick1_c ? we1_i    : we0_i;
            state          <= S_ACCESS;
          end
        end
        S_ACCESS: begin
          // SRAM samples the access on this edge; data returns during RESP.
          mem_write_en_o <= 1'b0;
          ack0_o         <= grant_o[0];
          ack1_o         <= grant_o[1];
          state          <= S_RESP;
        end
        S_RESP: begin
          ack0_o     <= 1'b0;
          ack1_o     <= 1'b0;
          last_grant <= grant_o[1];
          grant_o    <= 2'b00;
          state      <= S_IDLE;
        end
        default: begin
          mem_write_en_o <= 1'b0;
          ack0_o         <= 1'b0;
          ack1_o         <= 1'b0;
          grant_o        <= 2'b00;
          state          <= S_IDLE;
        end
      endcase
    end
  end

  // SRAM output is already registered, so read data passes straight through during ack.
  assign rdata0_o = ack0_o ? mem_rdata_i : '0;
  assign rdata1_o = ack1_o ? mem_rdata_i : '0;

`ifndef SYNTHESIS
  a_ack_excl: assert property (@(posedge clk) disable iff (!rst) !(ack0_o && ack1_o));
  a_grant_onehot: assert property (@(posedge clk) disable iff (!rst) $onehot0(grant_o));
  a_we_in_access: assert property (@(posedge clk) disable iff (!rst)
                                   mem_write_en_o |-> (state == S_ACCESS));
`endif

endmodule

// File: tb/tb_sram_arbiter.sv
// Scoreboard bench for sram_arbiter: drivers push expected responses, a negedge monitor checks acks.
`timescale 1ns/1ps
module tb_sram_arbiter;
  localparam int unsigned ADDR_W     = 32;
  localparam int unsigned DATA_W     = 32;
  localparam int unsigned SRAM_WORDS = 1024;
  localparam int          BUDGET     = 200;

  typedef struct {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic req0 = 1'b0, req1 = 1'b0, we0 = 1'b0, we1 = 1'b0;
  logic [ADDR_W-1:0] addr0 = '0, addr1 = '0;
  logic [DATA_W-1:0] wdata0 = '0, wdata1 = '0;
  logic ack0, ack1;
  logic [DATA_W-1:0] rdata0, rdata1;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata = '0;
  logic [1:0]        grant;

  always #5 clk = ~clk;

  sram_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst(rst),
    .req0_i(req0), .req1_i(req1), .we0_i(we0), .we1_i(we1),
    .addr0_i(addr0), .addr1_i(addr1), .wdata0_i(wdata0), .wdata1_i(wdata1),
    .ack0_o(ack0), .ack1_o(ack1), .rdata0_o(rdata0), .rdata1_o(rdata1),
    .mem_addr_o(mem_addr), .mem_write_en_o(mem_we), .mem_wdata_o(mem_wdata),
    .mem_rdata_i(mem_rdata), .grant_o(grant)
  );

  // Behavioural mem16k stand-in: registered read, word index from address bits [11:2].
  logic [DATA_W-1:0] sram [SRAM_WORDS];
  always @(posedge clk) begin
    if (mem_we) sram[mem_addr[11:2]] <= mem_wdata;
    mem_rdata <= sram[mem_addr[11:2]];
  end

  function automatic logic [DATA_W-1:0] init_word(input logic [9:0] idx);
    return 32'hC0DE_0000 ^ {22'd0, idx};
  endfunction

  // Reference memory: what each word should hold after all issued writes.
  logic [DATA_W-1:0] model [int unsigned];
  function automatic logic [DATA_W-1:0] model_rd(input logic [ADDR_W-1:0] a);
    int unsigned k;
    k = 32'(a[11:2]);
    if (model.exists(k)) return model[k];
    return init_word(a[11:2]);
  endfunction

  int checks = 0;
  int failures = 0;
  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endfunction

  exp_t exp_q0[$];
  exp_t exp_q1[$];
  int   order_q[$];

  int   cyc = 0;
  int   we_cnt = 0;
  logic prev_ack0 = 1'b0, prev_ack1 = 1'b0;
  int   ack_cyc0 = 0, ack_cyc1 = 0;

  function automatic void on_ack(input int p);
    exp_t e;
    logic [DATA_W-1:0] rd;
    logic prev;
    int want;
    rd   = (p == 0) ? rdata0 : rdata1;
    prev = (p == 0) ? prev_ack0 : prev_ack1;
    chk("ack_single_cycle", 32'(prev), 32'd0);
    if ((p == 0 && exp_q0.size() == 0) || (p == 1 && exp_q1.size() == 0)) begin
      checks++;
      failures++;
      $display("FAIL unexpected_ack: port %0d acked with 0 requests outstanding, expected no ack at %0t", p, $time);
      return;
    end
    if (p == 0) e = exp_q0.pop_front();
    else        e = exp_q1.pop_front();
    chk("grant_owner", 32'(grant), (p == 0) ? 32'd1 : 32'd2);
    chk("mem_addr", mem_addr, e.addr);
    chk("we_cycles", 32'(we_cnt), e.we ? 32'd1 : 32'd0);
    if (!e.we) chk("rdata", rd, e.data);
    if (order_q.size() > 0) begin
      want = order_q.pop_front();
      chk("grant_order", 32'(p), 32'(want));
    end
    if (p == 0) ack_cyc0 = cyc;
    else        ack_cyc1 = cyc;
  endfunction

  // Monitor: samples on the falling edge, away from the DUT's active edge.
  always @(negedge clk) begin
    if (!rst) begin
      we_cnt    = 0;
      prev_ack0 = 1'b0;
      prev_ack1 = 1'b0;
    end else begin
      cyc++;
      if (mem_we) we_cnt++;
      chk("grant_onehot0", 32'($onehot0(grant)), 32'd1);
      if (!ack0) chk("rdata0_quiet", rdata0, 32'd0);
      if (!ack1) chk("rdata1_quiet", rdata1, 32'd0);
      if (ack0 || ack1) chk("ack_exclusive", 32'(ack0 & ack1), 32'd0);
      if (ack0) on_ack(0);
      if (ack1) on_ack(1);
      if (ack0 || ack1) we_cnt = 0;
      prev_ack0 = ack0;
      prev_ack1 = ack1;
    end
  end

  // One access on port p; with hold set, req stays high for the caller's next access.
  task automatic access(input int p, input logic we, input logic [ADDR_W-1:0] a,
                        input logic [DATA_W-1:0] d, input bit hold, output int lat);
    exp_t e;
    logic cur;
    logic seen;
    cur = (p == 0) ? req0 : req1;
    if (!cur) begin
      @(posedge clk);
      #1;
    end
    e.we   = we;
    e.addr = a;
    e.data = we ? d : model_rd(a);
    if (we) model[32'(a[11:2])] = d;
    if (p == 0) begin
      exp_q0.push_back(e);
      req0 = 1'b1; we0 = we; addr0 = a; wdata0 = d;
    end else begin
      exp_q1.push_back(e);
      req1 = 1'b1; we1 = we; addr1 = a; wdata1 = d;
    end
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      seen = (p == 0) ? ack0 : ack1;
    end while (seen !== 1'b1 && lat < BUDGET);
    if (seen !== 1'b1) chk("ack_timeout", 32'(seen), 32'd1);
    @(posedge clk);
    #1;
    if (!hold) begin
      if (p == 0) req0 = 1'b0;
      else        req1 = 1'b0;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    #1 rst = 1'b0;
    repeat (2) @(negedge clk);
    #2 rst = 1'b1;
  endtask

  int lat_a, lat_b;

  initial begin
    for (int i = 0; i < int'(SRAM_WORDS); i++) sram[i] = init_word(10'(i));

    #1;
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_ack0", 32'(ack0), 32'd0);
    chk("rst_ack1", 32'(ack1), 32'd0);
    chk("rst_rdata0", rdata0, 32'd0);
    chk("rst_rdata1", rdata1, 32'd0);
    chk("rst_grant", 32'(grant), 32'd0);
    @(negedge clk);
    #2 rst = 1'b1;

    // Port 0 write then read back.
    access(0, 1'b1, 32'h10, 32'hDEAD_BEEF, 1'b0, lat_a);
    chk("lat_write0", 32'(lat_a), 32'd3);
    access(0, 1'b0, 32'h10, '0, 1'b0, lat_a);
    chk("lat_read0", 32'(lat_a), 32'd3);

    // Tie straight after reset: port 0 first, port 1 three cycles later.
    do_reset();
    order_q.push_back(0);
    order_q.push_back(1);
    fork
      access(0, 1'b0, 32'h10, '0, 1'b0, lat_a);
      access(1, 1'b0, 32'h10, '0, 1'b0, lat_b);
    join
    chk("tie_lat0", 32'(lat_a), 32'd3);
    chk("tie_spacing", 32'(ack_cyc1 - ack_cyc0), 32'd3);

    // Cross-port visibility and an untouched word.
    access(1, 1'b1, 32'h20, 32'h0000_00A5, 1'b0, lat_b);
    access(0, 1'b0, 32'h20, '0, 1'b0, lat_a);
    access(0, 1'b0, 32'h24, '0, 1'b0, lat_a);

    // Top-of-range address passes through unmodified.
    access(1, 1'b1, 32'hFFFF_FFF0, $urandom, 1'b0, lat_b);
    access(0, 1'b0, 32'hFFFF_FFF0, '0, 1'b0, lat_a);

    // Held request after ack is served again as a fresh access.
    access(0, 1'b1, 32'h30, 32'h1357_9BDF, 1'b0, lat_a);
    access(0, 1'b0, 32'h30, '0, 1'b1, lat_a);
    access(0, 1'b0, 32'h30, '0, 1'b0, lat_b);
    chk("held_relat", 32'(lat_b), 32'd3);

    // Reset during the ACCESS cycle of a write abandons it without an ack.
    @(posedge clk);
    #1;
    req0 = 1'b1; we0 = 1'b1; addr0 = 32'h40; wdata0 = 32'h0BAD_F00D;
    @(posedge clk);
    #2;
    chk("midrst_we_before", 32'(mem_we), 32'd1);
    rst = 1'b0;
    #1;
    chk("midrst_we", 32'(mem_we), 32'd0);
    chk("midrst_grant", 32'(grant), 32'd0);
    chk("midrst_ack0", 32'(ack0), 32'd0);
    req0 = 1'b0;
    we0  = 1'b0;
    repeat (2) @(negedge clk);
    #2 rst = 1'b1;
    access(1, 1'b0, 32'h10, '0, 1'b0, lat_b);
    chk("post_rst_lat1", 32'(lat_b), 32'd3);

    // Sustained contention from both ports.
    do_reset();
`ifdef SRAM_ARB_ROUND_ROBIN_EN
    for (int i = 0; i < 4; i++) begin
      order_q.push_back(0);
      order_q.push_back(1);
    end
`else
    for (int i = 0; i < 4; i++) order_q.push_back(0);
    for (int i = 0; i < 4; i++) order_q.push_back(1);
`endif
    fork
      begin
        for (int i = 0; i < 4; i++) begin
          access(0, 1'(i % 2), 32'h200 + 32'(i * 4), $urandom, 1'(i < 3), lat_a);
          chk("cont_lat0_min", 32'(lat_a >= 3), 32'd1);
        end
      end
      begin
        for (int j = 0; j < 4; j++) begin
          access(1, 1'(j % 2), 32'h300 + 32'(j * 4), $urandom, 1'(j < 3), lat_b);
          chk("cont_lat1_min", 32'(lat_b >= 3), 32'd1);
        end
      end
    join

    // Random traffic on disjoint per-port regions.
    fork
      begin
        for (int i = 0; i < 30; i++) begin
          repeat ($urandom_range(0, 3)) @(posedge clk);
          access(0, 1'($urandom_range(0, 1)), 32'h200 + 32'($urandom_range(0, 15)) * 32'd4,
                 $urandom, 1'b0, lat_a);
          chk("rand_lat0_min", 32'(lat_a >= 3), 32'd1);
        end
      end
      begin
        for (int j = 0; j < 30; j++) begin
          repeat ($urandom_range(0, 3)) @(posedge clk);
          access(1, 1'($urandom_range(0, 1)), 32'h300 + 32'($urandom_range(0, 15)) * 32'd4,
                 $urandom, 1'b0, lat_b);
          chk("rand_lat1_min", 32'(lat_b >= 3), 32'd1);
        end
      end
    join

    repeat (5) @(negedge clk);
    chk("queues_drained", 32'(exp_q0.size() + exp_q1.size() + order_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation still running at %0t, expected completion earlier", $time);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/sram_arbiter.md
# sram_arbiter

Two-port arbiter that shares the single-port `mem16k` SRAM between the generated `mod_main` core (port 0) and a second requester such as a loader or DMA engine (port 1). It accepts one word access at a time, sequences the SRAM's registered read timing, and returns an acknowledge with read data to the requester it granted. It sits between the requesters and the `mem16k` instance in `test_tb` and in FPGA top levels.

## Interface
Parameters:
- `ADDR_W`, 32: byte address width. The SRAM word address is `mem_addr_o[ADDR_W-1:2]`, sliced by the integrator.
- `DATA_W`, 32: data word width.

Ports:
- `clk` in 1: single clock; all state is updated on the rising edge.
- `rst` in 1: reset, asynchronous and active-low. `rst`=0 clears all state immediately.
- `req0_i` / `req1_i` in 1: access request. The requester holds it high, with stable address, data and write enable, until it sees ack.
- `we0_i` / `we1_i` in 1: 1 = write, 0 = read.
- `addr0_i` / `addr1_i` in ADDR_W: byte address.
- `wdata0_i` / `wdata1_i` in DATA_W: write data.
- `ack0_o` / `ack1_o` out 1: one-cycle completion pulse.
- `rdata0_o` / `rdata1_o` out DATA_W: read data, valid only while the matching ack is high.
- `mem_addr_o` out ADDR_W: address to SRAM.
- `mem_write_en_o` out 1: SRAM write strobe.
- `mem_wdata_o` out DATA_W: SRAM write data.
- `mem_rdata_i` in DATA_W: SRAM read data, registered inside the SRAM and valid one edge after the address is presented.
- `grant_o` out 2: one-hot owner of the current transaction; 00 when idle.

## Operation
The FSM has three states: IDLE, ACCESS and RESP.

- **IDLE**
  - If any `req` is sampled high at an edge, pick the winner, register its addr, wdata and we onto the `mem_*` outputs, set `grant_o`, and move to ACCESS.
  - If no request is high, stay in IDLE.
- **ACCESS** (exactly 1 cycle)
  - `mem_write_en_o` = registered we.
  - The SRAM samples the access at the edge that ends this cycle.
  - Move to RESP.
- **RESP** (exactly 1 cycle)
  - `mem_write_en_o` = 0.
  - `ack` of the granted port = 1.
  - `rdata` of the granted port = `mem_rdata_i`. This is combinational pass-through; the SRAM output is already registered.
  - Update the last-grant pointer, then move to IDLE.
- **Holding outputs:** `mem_addr_o` and `mem_wdata_o` hold their values through ACCESS and RESP, and keep the last values in IDLE.
- **Non-granted port:** ack = 0 and rdata = 0 at all times.
- **Requests sampled during ACCESS or RESP** are ignored. A requester that still holds req at the edge ending RESP is re-arbitrated in IDLE as a new access. A compliant requester drops req on that edge.
- **Write ack:** issued the same way as a read ack; rdata is don't-care but driven as the mux value.
- **Arbitration** happens only in IDLE and follows the Configuration rule.

## Timing
- **Reset values:**
  - `mem_addr_o`=0, `mem_wdata_o`=0, `mem_write_en_o`=0
  - `ack0_o`=`ack1_o`=0, `rdata*`=0, `grant_o`=00
  - state = IDLE; last-grant pointer = port 1, so port 0 wins the first tie.
- **Latency:** req sampled at edge k → `mem_write_en_o`/`mem_addr_o` valid after edge k → ack high during the cycle after edge k+1. This is 3 cycles from req rise to ack for an idle arbiter.
- **Throughput:** one access per 3 cycles. Back-to-back requests from different ports have no dead cycle beyond IDLE.
- **Simultaneous requests:** one is served and the other waits in place; its req stays high and no ack is lost.
- **Reset mid-transaction:** `mem_write_en_o` drops asynchronously with `rst`; the in-flight access is abandoned without an ack. An interrupted write may or may not have landed, and the requester must retry.
- **Wrap-around:** the address is passed unmodified, with no range checking.

## Configuration
- `SRAM_ARB_ROUND_ROBIN_EN` defined: on a tie, the port not granted last wins. Two continuously requesting ports alternate 0,1,0,1.
- Not defined: fixed priority, port 0 always wins a tie. Port 1 can be starved while port 0 keeps requesting. The last-grant pointer is still kept but ignored.

## Test plan
- **Write then read, port 0:** write 0xDEADBEEF to 0x10, then read 0x10. `mem_write_en_o` is high exactly one cycle; ack0 comes in the 3rd cycle; `rdata0_o`=0xDEADBEEF during ack.
- **Tie after reset:** both ports read 0x10 in the same cycle. ack0 first; ack1 exactly 3 cycles later with 0xDEADBEEF; ack1 never overlaps ack0.
- **Sustained contention:** both ports hold req for 4 transactions. With the macro, the grant order is 0,1,0,1. Without it, the order is 0,0,0,0 and ack1 never rises.
- **Cross-port visibility:** port 1 writes 0x0000_00A5 to 0x20; port 0 reads 0x20 → 0x0000_00A5. Port 0 reading 0x24 (never written) matches the SRAM model's content.
- **Reset mid-write:** drive `rst`=0 during ACCESS of a write. `mem_write_en_o`=0 immediately, no ack, `grant_o`=00. After `rst`=1, a new port 1 request completes normally.
- **Held req after ack:** port 0 keeps req high after ack → a second identical access with a second ack 3 cycles later; no ack is ever wider than one cycle.
